spi_fifo: RTL and testbench

SPI_FIFO -- requirements
Module: spi_fifo

---
 rtl/spi_fifo.sv | 143 ++++++++++++++
 tb/tb_spi_fifo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_fifo.sv
// spi_fifo: SPI master with byte-wide TX/RX FIFOs behind a four-register CPU port.
// Mode (fast/CPHA/CPOL) is captured at byte start; chip selects follow the control register immediately.
module spi_fifo #(
    parameter int CLK     = 36000000,
    parameter int FAST_HZ = 18000000,
    parameter int SLOW_HZ = 400000,
    parameter int DEPTH   = 8,
    parameter int NCS     = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           wr,
    input  logic           rd,
    input  logic [1:0]     adr,
    input  logic [7:0]     data_in,
    output logic [7:0]     data_out,
    output logic           busy,
    output logic           sclk,
    output logic           mosi,
    input  logic           miso,
    output logic [NCS-1:0] cs_n
);
    localparam int HF = CLK / (2 * FAST_HZ) < 1 ? 1 : CLK / (2 * FAST_HZ);
    localparam int HS = CLK / (2 * SLOW_HZ) < 1 ? 1 : CLK / (2 * SLOW_HZ);
    localparam int DW = $clog2(HF > HS ? HF : HS) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    state_t state;

    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic          tx_ovf, rx_ovf;
    logic [6:0]    ctrl;
    logic [7:0]    sh, rx_sh;
    logic [3:0]    hp;
    logic [DW-1:0] div, lim;
    logic          fast_l, cpha_l, cpol_l;
    logic          tx_empty, tx_full, rx_empty, rx_full;
    logic          tx_push, tx_pop, rx_push, rx_pop, edge_now, lead;
    logic [7:0]    status;

    always_comb begin
        tx_empty = tx_cnt == '0;
        tx_full  = tx_cnt == CW'(DEPTH);
        rx_empty = rx_cnt == '0;
        rx_full  = rx_cnt == CW'(DEPTH);
        tx_pop   = state == LOAD;
        tx_push  = wr && adr == 2'd0 && (!tx_full || tx_pop);
        rx_pop   = rd && adr == 2'd0 && !rx_empty;
        rx_push  = state == DONE && (!rx_full || rx_pop);
        busy     = state != IDLE || !tx_empty;
        status   = {1'b0, rx_ovf, tx_ovf, busy, rx_full, rx_empty, tx_full, tx_empty};
        lim      = fast_l ? DW'(HF - 1) : DW'(HS - 1);
        edge_now = state == SHIFT && div == lim;
        lead     = !hp[0];
    end

    always_comb begin
        cs_n = '1;
        for (int i = 0; i < NCS; i++)
            cs_n[i] = ctrl[3] && ctrl[2:0] == 3'(i) ? 1'b0 : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= data_in;
        if (rx_push) rx_mem[rx_wp] <= rx_sh;
        if (reset) begin
            state    <= IDLE;
            tx_wp    <= '0;
            tx_rp    <= '0;
            rx_wp    <= '0;
            rx_rp    <= '0;
            tx_cnt   <= '0;
            rx_cnt   <= '0;
            tx_ovf   <= 1'b0;
            rx_ovf   <= 1'b0;
            ctrl     <= '0;
            sh       <= '0;
            rx_sh    <= '0;
            hp       <= '0;
            div      <= '0;
            fast_l   <= 1'b0;
            cpha_l   <= 1'b0;
            cpol_l   <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b1;
            data_out <= 8'h00;
        end else begin
            if (tx_push) tx_wp <= tx_wp + AW'(1);
            if (tx_pop) tx_rp <= tx_rp + AW'(1);
            if (rx_push) rx_wp <= rx_wp + AW'(1);
            if (rx_pop) rx_rp <= rx_rp + AW'(1);
            tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
            rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
            tx_ovf <= (tx_ovf && !(wr && adr == 2'd2)) || (wr && adr == 2'd0 && !tx_push);
            rx_ovf <= (rx_ovf && !(wr && adr == 2'd2)) || (state == DONE && !rx_push);
            if (wr && adr == 2'd1) ctrl <= data_in[6:0];
            if (rd)
                data_out <= adr == 2'd0 ? (rx_empty ? 8'hFF : rx_mem[rx_rp]) :
                            adr == 2'd1 ? status :
                            adr == 2'd2 ? 8'(tx_cnt) : 8'h00;
            case (state)
                IDLE: begin
                    sclk <= ctrl[6];
                    if (!tx_empty) state <= LOAD;
                end
                LOAD: begin
                    sh     <= tx_mem[tx_rp];
                    fast_l <= ctrl[4];
                    cpha_l <= ctrl[5];
                    cpol_l <= ctrl[6];
                    sclk   <= ctrl[6];
                    if (!ctrl[5]) mosi <= tx_mem[tx_rp][7];
                    div    <= '0;
                    hp     <= '0;
                    state  <= SHIFT;
                end
                SHIFT: begin
                    div <= edge_now ? '0 : div + DW'(1);
                    if (edge_now) begin
                        sclk <= !sclk;
                        hp   <= hp + 4'd1;
                        // sample on the edge CPHA selects; the last CPHA=0 trailing edge leaves mosi alone
                        if (lead != cpha_l) rx_sh <= {rx_sh[6:0], miso};
                        else if (cpha_l || hp != 4'd15) begin
                            mosi <= cpha_l ? sh[7] : sh[6];
                            sh   <= {sh[6:0], 1'b0};
                        end
                        if (hp == 4'd15) state <= DONE;
                    end
                end
                default: begin
                    sclk  <= cpol_l;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_fifo.sv
// tb_spi_fifo: directed stimulus with a scoreboard; reads and observations are queued and
// compared by a separate monitor process on the falling clock edge.
module tb_spi_fifo;
    localparam int DEPTH = 8;

    logic       clk = 1'b0, reset, wr, rd, miso, sclk, mosi, busy;
    logic [1:0] adr, cs_n;
    logic [7:0] data_in, data_out;
    logic       loop, miso_v, rd_seen = 1'b0;

    typedef struct {
        string       n;
        logic [15:0] a;
        logic [15:0] e;
    } obs_t;

    obs_t       obs_q[$];
    logic [7:0] exp_q[$];
    string      exp_n[$];
    int         checks = 0, passed = 0;

    int         cyc = 0, last_edge = 0, last_gap = 0, edges = 0, rises = 0, bad_mosi = 0;
    logic [7:0] mosi_rise = 8'h00;
    logic       prev_sclk = 1'b0, prev_mosi = 1'b1;

    spi_fifo dut (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .adr(adr), .data_in(data_in),
        .data_out(data_out), .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    assign miso = loop ? mosi : miso_v;

    always #5 clk = ~clk;

    always @(posedge clk) rd_seen <= rd;

    task automatic compare(input string n, input logic [15:0] a, input logic [15:0] e);
        checks++;
        if (a === e) passed++;
        else $display("FAIL %s got %0h required %0h", n, a, e);
    endtask

    always @(negedge clk) begin : mon
        logic [7:0] e;
        string      n;
        obs_t       o;
        cyc++;
        if (sclk !== prev_sclk) begin
            edges++;
            last_gap  = cyc - last_edge;
            last_edge = cyc;
            if (sclk) begin
                rises++;
                mosi_rise = {mosi_rise[6:0], mosi};
            end
        end
        if (mosi !== prev_mosi && !(prev_sclk && !sclk)) bad_mosi++;
        prev_sclk = sclk;
        prev_mosi = mosi;
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_read got %0h required none", data_out);
            end else begin
                e = exp_q.pop_front();
                n = exp_n.pop_front();
                compare(n, 16'(data_out), 16'(e));
            end
        end
        while (obs_q.size() != 0) begin
            o = obs_q.pop_front();
            compare(o.n, o.a, o.e);
        end
    end

    task automatic wreg(input logic [1:0] a, input logic [7:0] d);
        wr = 1'b1;
        adr = a;
        data_in = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic rreg(input logic [1:0] a, input logic [7:0] e, input string n);
        rd = 1'b1;
        adr = a;
        exp_q.push_back(e);
        exp_n.push_back(n);
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic post(input string n, input logic [15:0] a, input logic [15:0] e);
        obs_t o;
        o.n = n;
        o.a = a;
        o.e = e;
        obs_q.push_back(o);
    endtask

    task automatic wait_idle(input int lim, input string n);
        int i = 0;
        while (busy && i < lim) begin
            @(negedge clk);
            i++;
        end
        post(n, 16'(busy), 16'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, b0, e0, k;
        reset = 1'b1; wr = 1'b0; rd = 1'b0; adr = 2'd0; data_in = 8'h00;
        loop = 1'b0; miso_v = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        post("rst_sclk", 16'(sclk), 16'd0);
        post("rst_mosi", 16'(mosi), 16'd1);
        post("rst_busy", 16'(busy), 16'd0);
        post("rst_cs_n", 16'(cs_n), 16'h3);
        post("rst_data_out", 16'(data_out), 16'h00);
        rreg(2'd1, 8'h05, "rst_status");
        rreg(2'd0, 8'hFF, "rst_rx_empty");
        rreg(2'd2, 8'h00, "rst_txcnt");
        wreg(2'd3, 8'hAB);
        rreg(2'd3, 8'h00, "reserved_read");

        wreg(2'd1, 8'h09); post("cs_09", 16'(cs_n), 16'h1);
        wreg(2'd1, 8'h0F); post("cs_0f", 16'(cs_n), 16'h3);
        wreg(2'd1, 8'h08); post("cs_08", 16'(cs_n), 16'h2);
        wreg(2'd1, 8'h00); post("cs_00", 16'(cs_n), 16'h3);

        // mode 0, fast, miso looped to mosi
        loop = 1'b1;
        wreg(2'd1, 8'h18);
        r0 = rises;
        wreg(2'd0, 8'hA5);
        wait_idle(200, "m0_idle");
        post("m0_rises", 16'(rises - r0), 16'd8);
        post("m0_mosi_bits", 16'(mosi_rise), 16'hA5);
        post("m0_half_gap", 16'(last_gap), 16'd1);
        post("m0_sclk_idle", 16'(sclk), 16'd0);
        rreg(2'd0, 8'hA5, "m0_rx");
        rreg(2'd1, 8'h05, "m0_status");

        // mode 3, slow, miso held high
        loop = 1'b0; miso_v = 1'b1;
        wreg(2'd1, 8'h68);
        @(negedge clk);
        post("m3_sclk_idle_high", 16'(sclk), 16'd1);
        @(negedge clk);
        r0 = rises; b0 = bad_mosi;
        wreg(2'd0, 8'h3C);
        wait_idle(1000, "m3_idle");
        post("m3_rises", 16'(rises - r0), 16'd8);
        post("m3_mosi_bits", 16'(mosi_rise), 16'h3C);
        post("m3_half_gap", 16'(last_gap), 16'd45);
        post("m3_mosi_on_fall_only", 16'(bad_mosi - b0), 16'd0);
        post("m3_sclk_end", 16'(sclk), 16'd1);
        rreg(2'd0, 8'hFF, "m3_rx");
        rreg(2'd1, 8'h05, "m3_status");

        // overflow on both FIFOs: DEPTH+2 pushes, one is in flight when the TX FIFO fills
        loop = 1'b1;
        wreg(2'd1, 8'h10);
        @(negedge clk);
        for (int i = 0; i < DEPTH + 2; i++) wreg(2'd0, 8'(16 + i));
        rreg(2'd1, 8'h36, "ovf_status_txfull");
        rreg(2'd2, 8'h08, "ovf_txcnt");
        wait_idle(1000, "ovf_idle");
        rreg(2'd1, 8'h69, "ovf_status_rxfull");
        wreg(2'd2, 8'h00);
        rreg(2'd1, 8'h09, "ovf_cleared");
        for (int i = 0; i < DEPTH; i++) rreg(2'd0, 8'(16 + i), "rx_order");
        rreg(2'd0, 8'hFF, "rx_drained");
        rreg(2'd1, 8'h05, "rx_drained_status");

        // reset in the middle of a slow byte
        loop = 1'b0; miso_v = 1'b1;
        wreg(2'd1, 8'h08);
        e0 = edges;
        wreg(2'd0, 8'h55);
        k = 0;
        while (edges - e0 < 7 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        post("mid_edges", 16'(edges - e0), 16'd7);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        post("mid_sclk", 16'(sclk), 16'd0);
        post("mid_cs_n", 16'(cs_n), 16'h3);
        post("mid_mosi", 16'(mosi), 16'd1);
        post("mid_data_out", 16'(data_out), 16'h00);
        rreg(2'd1, 8'h05, "mid_status");
        rreg(2'd0, 8'hFF, "mid_no_rx");
        rreg(2'd2, 8'h00, "mid_txcnt");
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
